// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : clock_set_ctrl
// Brief   : Set-mode controller for the HHMMSS timer. Captures the running
//           time, splits it into h/m/s by repeated subtraction, lets the user
//           edit each field with up/down presses while that field blinks,
//           then writes the edited time back with a one-cycle load strobe.
// Revision: 1.0 - initial release
// ============================================================================
module clock_set_ctrl #(
  parameter int IDLE_TIMEOUT = 1_000_000_000,
  parameter int BLINK_HALF   = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_pulse,
  input  logic        up_pulse,
  input  logic        down_pulse,
  input  logic [23:0] cur_time,
  output logic        timer_run,
  output logic        load_strobe,
  output logic [23:0] load_value,
  output logic        set_active,
  output logic [1:0]  field,
  output logic [5:0]  blink_mask
);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_CAPTURE = 3'd1,
    S_SET_H   = 3'd2,
    S_SET_M   = 3'd3,
    S_SET_S   = 3'd4,
    S_COMMIT  = 3'd5
  } state_t;

  localparam logic [31:0] C_IDLE_LAST  = 32'(IDLE_TIMEOUT - 1);
  localparam logic [31:0] C_BLINK_LAST = 32'(BLINK_HALF - 1);

  state_t      state_q, state_d;
  logic [23:0] work_q, work_d;
  logic [4:0]  h_q, h_d;
  logic [5:0]  m_q, m_d;
  logic [5:0]  s_q, s_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] bcnt_q, bcnt_d;
  logic        phase_q, phase_d;

  logic        timer_run_q, timer_run_d;
  logic        load_strobe_q, load_strobe_d;
  logic [23:0] load_value_q, load_value_d;
  logic        set_active_q, set_active_d;
  logic [1:0]  field_q, field_d;
  logic [5:0]  blink_mask_q, blink_mask_d;

  logic        any_pulse;
  logic        next_in_set;

  // Wrapping increment/decrement; up and down together cancel out.
  function automatic logic [5:0] step_field(input logic [5:0] v,
                                            input logic [5:0] max_v,
                                            input logic       up,
                                            input logic       dn);
    if (up && !dn)      return (v == max_v) ? 6'd0 : v + 6'd1;
    else if (dn && !up) return (v == 6'd0) ? max_v : v - 6'd1;
    else                return v;
  endfunction

  // Next-state, datapath and output decode.
  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    h_d          = h_q;
    m_d          = m_q;
    s_d          = s_q;
    idle_d       = idle_q;
    bcnt_d       = bcnt_q;
    phase_d      = phase_q;
    load_value_d = load_value_q;
    any_pulse    = mode_pulse | up_pulse | down_pulse;

    case (state_q)
      S_RUN: begin
        if (mode_pulse) begin
          work_d  = cur_time;
          h_d     = 5'd0;
          m_d     = 6'd0;
          s_d     = 6'd0;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        // Keep subtracting past saturation so out-of-range input clamps.
        if (work_q >= 24'd10000) begin
          work_d = work_q - 24'd10000;
          if (h_q != 5'd23) h_d = h_q + 5'd1;
        end else if (work_q >= 24'd100) begin
          work_d = work_q - 24'd100;
          if (m_q != 6'd59) m_d = m_q + 6'd1;
        end else begin
          s_d     = (work_q[6:0] > 7'd59) ? 6'd59 : work_q[5:0];
          state_d = S_SET_H;
          idle_d  = 32'd0;
          bcnt_d  = 32'd0;
          phase_d = 1'b0;
        end
      end

      S_SET_H, S_SET_M, S_SET_S: begin
        if (mode_pulse) begin
          // Mode wins over a simultaneous edit; the edit is dropped.
          case (state_q)
            S_SET_H: state_d = S_SET_M;
            S_SET_M: state_d = S_SET_S;
            default: begin
              state_d      = S_COMMIT;
              load_value_d = ({19'd0, h_q} * 24'd10000)
                           + ({18'd0, m_q} * 24'd100)
                           + {18'd0, s_q};
            end
          endcase
        end else begin
          case (state_q)
            S_SET_H: h_d = 5'(step_field({1'b0, h_q}, 6'd23, up_pulse, down_pulse));
            S_SET_M: m_d = step_field(m_q, 6'd59, up_pulse, down_pulse);
            default: s_d = step_field(s_q, 6'd59, up_pulse, down_pulse);
          endcase
        end

        if (any_pulse) begin
          idle_d = 32'd0;
        end else if (idle_q == C_IDLE_LAST) begin
          idle_d  = 32'd0;
          state_d = S_RUN;
        end else begin
          idle_d = idle_q + 32'd1;
        end

        // Any press restarts the blink so edited digits show immediately.
        if (any_pulse) begin
          bcnt_d  = 32'd0;
          phase_d = 1'b0;
        end else if (bcnt_q == C_BLINK_LAST) begin
          bcnt_d  = 32'd0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 32'd1;
        end
      end

      S_COMMIT: state_d = S_RUN;

      default: state_d = S_RUN;
    endcase

    next_in_set = (state_d == S_SET_H) || (state_d == S_SET_M) || (state_d == S_SET_S);
    if (!next_in_set) begin
      idle_d  = 32'd0;
      bcnt_d  = 32'd0;
      phase_d = 1'b0;
    end

    timer_run_d   = (state_d == S_RUN);
    set_active_d  = (state_d != S_RUN);
    load_strobe_d = (state_d == S_COMMIT);

    field_d = 2'd0;
    case (state_d)
      S_SET_H: field_d = 2'd1;
      S_SET_M: field_d = 2'd2;
      S_SET_S: field_d = 2'd3;
      default: field_d = 2'd0;
    endcase

    blink_mask_d = 6'b000000;
    if (phase_d) begin
      case (state_d)
        S_SET_H: blink_mask_d = 6'b110000;
        S_SET_M: blink_mask_d = 6'b001100;
        S_SET_S: blink_mask_d = 6'b000011;
        default: blink_mask_d = 6'b000000;
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RUN;
      work_q        <= 24'd0;
      h_q           <= 5'd0;
      m_q           <= 6'd0;
      s_q           <= 6'd0;
      idle_q        <= 32'd0;
      bcnt_q        <= 32'd0;
      phase_q       <= 1'b0;
      timer_run_q   <= 1'b1;
      load_strobe_q <= 1'b0;
      load_value_q  <= 24'd0;
      set_active_q  <= 1'b0;
      field_q       <= 2'd0;
      blink_mask_q  <= 6'd0;
    end else begin
      state_q       <= state_d;
      work_q        <= work_d;
      h_q           <= h_d;
      m_q           <= m_d;
      s_q           <= s_d;
      idle_q        <= idle_d;
      bcnt_q        <= bcnt_d;
      phase_q       <= phase_d;
      timer_run_q   <= timer_run_d;
      load_strobe_q <= load_strobe_d;
      load_value_q  <= load_value_d;
      set_active_q  <= set_active_d;
      field_q       <= field_d;
      blink_mask_q  <= blink_mask_d;
    end
  end

  assign timer_run   = timer_run_q;
  assign load_strobe = load_strobe_q;
  assign load_value  = load_value_q;
  assign set_active  = set_active_q;
  assign field       = field_q;
  assign blink_mask  = blink_mask_q;

endmodule
`default_nettype wire
